aec_tokenizer: RTL and testbench

Front-end lexer for the arithmetic expression calculator (AEC) datapath. It accepts the raw `ready`/`ascii_in` character stream, one character per cycle, terminated by `=`. It classifies each character into a typed token, checks parenthesis balance, and buffers the tokens in a FIFO. The evaluator core drains that FIFO with a valid/ready handshake, which decouples the no-backpressure character source from evaluator stalls.

---
 rtl/aec_pkg.sv | 62 ++++++
 rtl/aec_tok_fifo.sv | 60 ++++++
 rtl/aec_tokenizer.sv | 99 +++++++++
 tb/tb_aec_tokenizer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// Shared types and constants for the AEC tokenizer: token codes, ASCII codes, character classifier.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package aec_pkg;

  typedef enum logic [2:0] {
    TOK_NUM = 3'd0,
    TOK_ADD = 3'd1,
    TOK_SUB = 3'd2,
    TOK_MUL = 3'd3,
    TOK_LP  = 3'd4,
    TOK_RP  = 3'd5,
    TOK_END = 3'd6,
    TOK_BAD = 3'd7
  } tok_t;

  // One FIFO entry: type in the upper 3 bits, operand value in the lower 4.
  typedef struct packed {
    tok_t       typ;
    logic [3:0] val;
  } tok_s;

  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] ASC_A   = 8'h61;
  localparam logic [7:0] ASC_F   = 8'h66;
  localparam logic [7:0] ASC_ADD = 8'h2B;
  localparam logic [7:0] ASC_SUB = 8'h2D;
  localparam logic [7:0] ASC_MUL = 8'h2A;
  localparam logic [7:0] ASC_LP  = 8'h28;
  localparam logic [7:0] ASC_RP  = 8'h29;
  localparam logic [7:0] ASC_EQ  = 8'h3D;

  localparam int AEC_DEPTH = 16;

  // Map one byte to its token. Digit values come straight from the low
  // nibble ('0'..'9' = 0x30..0x39); 'a'..'f' have low nibble 1..6, so +9.
  function automatic tok_s classify(input logic [7:0] c);
    tok_s t;
    t.typ = TOK_BAD;
    t.val = 4'd0;
    if (c >= ASC_0 && c <= ASC_9) begin
      t.typ = TOK_NUM;
      t.val = c[3:0];
    end else if (c >= ASC_A && c <= ASC_F) begin
      t.typ = TOK_NUM;
      t.val = c[3:0] + 4'd9;
    end else begin
      case (c)
        ASC_ADD: t.typ = TOK_ADD;
        ASC_SUB: t.typ = TOK_SUB;
        ASC_MUL: t.typ = TOK_MUL;
        ASC_LP:  t.typ = TOK_LP;
        ASC_RP:  t.typ = TOK_RP;
        ASC_EQ:  t.typ = TOK_END;
        default: t.typ = TOK_BAD;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/aec_tok_fifo.sv
// Token FIFO, 7-bit entries, with a tail-overwrite path so END always lands.
// Latency: a write appears at the head after the write edge; no write-to-read bypass.
// Backpressure: push accepted when not full or when popping the same cycle; refused pushes are dropped.
module aec_tok_fifo
  import aec_pkg::*;
#(
  parameter int DEPTH = AEC_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [6:0] push_dat,
  input  logic       ovw,
  input  logic       pop,
  output logic [6:0] head_dat,
  output logic       full,
  output logic       empty
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [6:0]       mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] tail_idx;
  logic             pop_en;
  logic             push_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_en   = pop && !empty;
  assign push_en  = push && (!full || pop_en);
  assign tail_idx = wr_ptr[PTR_W-1:0] - PTR_ONE[PTR_W-1:0];
  assign head_dat = mem[rd_ptr[PTR_W-1:0]];

  // Storage writes: normal append, or rewrite of the newest entry when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_en) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_dat;
    end else if (ovw && full) begin
      mem[tail_idx] <= push_dat;
    end
  end

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/aec_tokenizer.sv
// AEC lexer: classifies one character per cycle, tracks paren depth, queues tokens for the evaluator.
// Latency: token visible at the FIFO head the cycle after its character is sampled.
// Backpressure: none toward the character source; consumer stalls fill the FIFO, overflow drops and flags err.
module aec_tokenizer
  import aec_pkg::*;
#(
  parameter int DEPTH = AEC_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       tok_valid,
  output logic [2:0] tok_type,
  output logic [3:0] tok_val,
  input  logic       tok_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state, state_nxt;
  logic [4:0] depth, depth_nxt, depth_base;
  logic       err_nxt;
  tok_s       cur;
  logic [6:0] head;
  logic       start, cap, pop_fire, drop, ovw, full, empty;

  assign cur       = classify(ascii_in);
  assign start     = (state == ST_IDLE) && ready;
  assign cap       = start || (state == ST_RECV);
  assign tok_valid = !empty;
  assign pop_fire  = tok_valid && tok_ready;
  assign drop      = cap && full && !pop_fire;
  // END must reach the consumer, so a refused END replaces the newest entry.
  assign ovw       = drop && (cur.typ == TOK_END);
  assign tok_type  = head[6:4];
  assign tok_val   = head[3:0];
  assign busy      = (state != ST_IDLE);

  aec_tok_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cap),
    .push_dat (cur),
    .ovw      (ovw),
    .pop      (pop_fire),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  // Next state, paren depth and error flag; a new expression starts from depth 0 and err 0.
  always_comb begin
    depth_base = start ? 5'd0 : depth;
    depth_nxt  = depth_base;
    err_nxt    = start ? 1'b0 : err;
    state_nxt  = state;
    if (cap) begin
      case (cur.typ)
        TOK_LP: begin
          if (depth_base == 5'd31) err_nxt = 1'b1;
          else depth_nxt = depth_base + 5'd1;
        end
        TOK_RP: begin
          if (depth_base == 5'd0) err_nxt = 1'b1;
          else depth_nxt = depth_base - 5'd1;
        end
        TOK_END: begin
          if (depth_base != 5'd0) err_nxt = 1'b1;
          state_nxt = ST_DRAIN;
        end
        TOK_BAD: err_nxt = 1'b1;
        default: ;
      endcase
      if (drop && (cur.typ != TOK_END)) err_nxt = 1'b1;
      if (start && (cur.typ != TOK_END)) state_nxt = ST_RECV;
    end
    if ((state == ST_DRAIN) && pop_fire && (head[6:4] == TOK_END)) state_nxt = ST_IDLE;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      depth <= 5'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aec_tokenizer.sv
// Self-checking bench for aec_tokenizer: reference model feeds a scoreboard queue, a monitor pops on handshake.
// Latency: checks first-token visibility, busy rise/fall and err timing around each expression.
// Backpressure: consumer ready is held high, randomised, or held low to force overflow.
module tb_aec_tokenizer;
  import aec_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] ascii_in = 8'd0;
  logic       tok_ready = 1'b0;
  logic       tok_valid, busy, err;
  logic [2:0] tok_type;
  logic [3:0] tok_val;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;              // 0: always ready, 1: random, 2: stalled
  logic [6:0] exp_q[$];
  byte unsigned expr[$];
  bit exp_err, exp_err_first;

  aec_tokenizer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .ascii_in  (ascii_in),
    .tok_valid (tok_valid),
    .tok_type  (tok_type),
    .tok_val   (tok_val),
    .tok_ready (tok_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Token code {type,val} of one character, straight from the character table.
  function automatic logic [6:0] ref_tok(input byte unsigned c);
    if (c >= "0" && c <= "9") return {3'd0, 4'(c - "0")};
    if (c >= "a" && c <= "f") return {3'd0, 4'(c - "a" + 10)};
    case (c)
      "+": return {3'd1, 4'd0};
      "-": return {3'd2, 4'd0};
      "*": return {3'd3, 4'd0};
      "(": return {3'd4, 4'd0};
      ")": return {3'd5, 4'd0};
      "=": return {3'd6, 4'd0};
      default: return {3'd7, 4'd0};
    endcase
  endfunction

  // Expected token list and err for the expression in expr. When stalled,
  // the consumer never pops: only DEPTH slots exist, END takes the last one.
  task automatic model_expr(input bit stalled);
    int d = 0;
    int n;
    logic [6:0] t;
    logic [6:0] toks[$];
    exp_err = 0;
    exp_err_first = 0;
    n = expr.size() - 1;
    for (int i = 0; i < expr.size(); i++) begin
      t = ref_tok(expr[i]);
      case (t[6:4])
        3'd4: if (d == 31) exp_err = 1; else d++;
        3'd5: if (d == 0) exp_err = 1; else d--;
        3'd6: if (d != 0) exp_err = 1;
        3'd7: exp_err = 1;
        default: ;
      endcase
      if (i == 0) exp_err_first = exp_err;
      toks.push_back(t);
    end
    if (stalled && n >= DEPTH) begin
      if (n > DEPTH) exp_err = 1;
      toks = toks[0:DEPTH-2];
      toks.push_back({3'd6, 4'd0});
    end
    foreach (toks[i]) exp_q.push_back(toks[i]);
  endtask

  task automatic load(input string s);
    expr.delete();
    for (int i = 0; i < s.len(); i++) expr.push_back(s[i]);
  endtask

  task automatic send(input bit stalled, input bit noisy_ready);
    model_expr(stalled);
    @(posedge clk); #1;
    for (int i = 0; i < expr.size(); i++) begin
      ready = (i == 0) ? 1'b1 : (noisy_ready && ($urandom_range(0, 3) == 0));
      ascii_in = expr[i];
      if (i == 0) check("tok_valid_before_first", tok_valid, 0);
      @(posedge clk); #1;
      if (i == 0) begin
        check("tok_valid_latency", tok_valid, 1);
        check("busy_rise", busy, 1);
        check("err_at_start", err, exp_err_first);
      end
    end
    ready = 1'b0;
    ascii_in = 8'($urandom);
    check("err_final", err, exp_err);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drain_done"}, busy, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tok_ready = 1'b1;
        1: tok_ready = 1'($urandom_range(0, 1));
        default: tok_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares popped tokens against the scoreboard, head stability and busy fall.
  logic [6:0] stall_dat;
  bit stall_prev = 0;
  bit end_seen = 0;
  always @(negedge clk) begin
    logic [6:0] exp;
    if (end_seen) begin
      check("busy_fall", busy, 0);
      end_seen = 0;
    end
    if (stall_prev && tok_valid) check("head_stable", {tok_type, tok_val}, stall_dat);
    stall_prev = tok_valid && !tok_ready && rst;
    stall_dat = {tok_type, tok_val};
    if (tok_valid && tok_ready && rst) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_token: got %0d, expected none", {tok_type, tok_val});
      end else begin
        exp = exp_q.pop_front();
        check("token", {tok_type, tok_val}, exp);
        if (exp[6:4] == 3'd6) end_seen = 1;
      end
    end
  end

  initial begin
    string dir[$];
    string alph;
    dir = '{"3+4*(2-1)=", "a*f=", "(1+2=", ")1=", "1#2=", "=", "9-b*(c+0)=", "))((=" };

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_type", tok_type, 0);
    check("rst_tok_val", tok_val, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed expressions with an always-ready consumer.
    rdy_mode = 0;
    foreach (dir[i]) begin
      load(dir[i]);
      send(0, 0);
      wait_idle("directed");
    end

    // Paren depth saturation: 33 opens then 33 closes.
    expr.delete();
    for (int i = 0; i < 33; i++) expr.push_back("(");
    for (int i = 0; i < 33; i++) expr.push_back(")");
    expr.push_back("=");
    send(0, 0);
    wait_idle("deep_paren");

    // Overflow with a stalled consumer, then release.
    alph = "0123456789abcdef+-*";
    for (int r = 0; r < 2; r++) begin
      rdy_mode = 2;
      expr.delete();
      for (int i = 0; i < 19 - r * 3; i++) expr.push_back(alph[$urandom_range(0, alph.len() - 1)]);
      expr.push_back("=");
      send(1, 0);
      rdy_mode = 0;
      wait_idle("overflow");
    end

    // Random short expressions with random consumer stalls.
    alph = "0123456789abcdef+-*()()#Zg ";
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(0, 14);
      expr.delete();
      for (int i = 0; i < len; i++) expr.push_back(alph[$urandom_range(0, alph.len() - 1)]);
      expr.push_back("=");
      send(0, 1);
      wait_idle("random");
    end

    // Reset mid-expression.
    rdy_mode = 0;
    load("12+#3");
    model_expr(0);
    @(posedge clk); #1;
    for (int i = 0; i < expr.size(); i++) begin
      ready = (i == 0);
      ascii_in = expr[i];
      @(posedge clk); #1;
    end
    ready = 1'b0;
    check("err_before_reset", err, 1);
    check("busy_before_reset", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("reset_tok_valid", tok_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    load("5=");
    send(0, 0);
    wait_idle("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
